// File: rtl/bsg_xor_checksum.sv
// Streaming XOR checksum: lanes of each beat are XOR-reduced and folded across a packet.
// Optional beat counter output count_o is enabled by defining BSG_XOR_CHECKSUM_COUNT_EN.

module bsg_xor #(
  parameter int width_p  = 1,
  parameter int harden_p = 0
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] o
);
  // A hardened macro would be dropped in here; both flavours are functionally identical.
  if (harden_p != 0) begin : g_hard
    assign o = a_i ^ b_i;
  end else begin : g_soft
    assign o = a_i ^ b_i;
  end
endmodule

module bsg_xor_checksum #(
  parameter int width_p  = 8,
  parameter int els_p    = 1,
  parameter int harden_p = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p*els_p-1:0]   data_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i
`ifdef BSG_XOR_CHECKSUM_COUNT_EN
  ,output logic [15:0]               count_o
`endif
);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e             state_reg;
  logic [width_p-1:0] acc_reg;
  logic [width_p-1:0] data_reg;
  logic               first_reg;
  logic               v_reg;
  logic [width_p-1:0] red;
  logic [width_p-1:0] nacc;
  logic               accept;
  logic [width_p-1:0] lane_x [els_p];

  // Lane reduction as a chain: lane_x[k] holds XOR of lanes 0..k.
  assign lane_x[0] = data_i[width_p-1:0];

  genvar gi;
  generate
    for (gi = 1; gi < els_p; gi++) begin : g_lane
      bsg_xor #(.width_p(width_p), .harden_p(harden_p)) lane_xor (
        .a_i (lane_x[gi-1]),
        .b_i (data_i[gi*width_p +: width_p]),
        .o   (lane_x[gi])
      );
    end
  endgenerate

  assign red     = lane_x[els_p-1];
  assign ready_o = (state_reg == ACCUM) | yumi_i;
  assign accept  = v_i & ready_o;
  // In HOLD acc is 0 and first is 1, so a beat accepted alongside yumi starts a fresh packet.
  assign nacc    = first_reg ? red : (acc_reg ^ red);
  assign v_o     = v_reg;
  assign data_o  = data_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      data_reg  <= '0;
      first_reg <= 1'b1;
      v_reg     <= 1'b0;
    end else if (accept) begin
      if (last_i) begin
        data_reg  <= nacc;
        acc_reg   <= '0;
        first_reg <= 1'b1;
        state_reg <= HOLD;
        v_reg     <= 1'b1;
      end else begin
        acc_reg   <= nacc;
        first_reg <= 1'b0;
        state_reg <= ACCUM;
        v_reg     <= 1'b0;
      end
    end else if (state_reg == HOLD && yumi_i) begin
      state_reg <= ACCUM;
      v_reg     <= 1'b0;
    end
  end

`ifdef BSG_XOR_CHECKSUM_COUNT_EN
  logic [15:0] cnt_reg;
  logic [15:0] count_reg;
  logic [15:0] cnt_next;

  assign cnt_next = first_reg ? 16'd1
                  : ((cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1);
  assign count_o  = count_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_reg   <= '0;
      count_reg <= '0;
    end else if (accept) begin
      if (last_i) begin
        count_reg <= cnt_next;
        cnt_reg   <= '0;
      end else begin
        cnt_reg   <= cnt_next;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
  assert property (@(posedge clk_i) (width_p >= 1) && (els_p >= 1));
`endif

endmodule

// File: tb/tb_bsg_xor_checksum.sv
// Directed and random checks of bsg_xor_checksum against a packet-level XOR reference model.
module tb_bsg_xor_checksum;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i, last_i, yumi_i;
  logic [15:0] data_i;
  logic        ready_o, v_o;
  logic [7:0]  data_o;
`ifdef BSG_XOR_CHECKSUM_COUNT_EN
  logic [15:0] count_o;
`endif

  logic        b_v, b_last, b_yumi;
  logic [31:0] b_data;
  logic        b_ready, b_v_o;
  logic [31:0] b_data_o;
`ifdef BSG_XOR_CHECKSUM_COUNT_EN
  logic [15:0] b_count;
`endif

  always #5 clk = ~clk;

  bsg_xor_checksum #(.width_p(8), .els_p(2), .harden_p(0)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
`ifdef BSG_XOR_CHECKSUM_COUNT_EN
    , .count_o(count_o)
`endif
  );

  bsg_xor_checksum #(.width_p(32), .els_p(1), .harden_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .v_i(b_v), .data_i(b_data), .last_i(b_last),
    .ready_o(b_ready), .v_o(b_v_o), .data_o(b_data_o), .yumi_i(b_yumi)
`ifdef BSG_XOR_CHECKSUM_COUNT_EN
    , .count_o(b_count)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_pkts   = 0;

  // Reference model: checksum = XOR of every lane of every beat in the packet.
  logic [7:0]  m_pkt;
  logic        m_valid;
  logic [7:0]  m_data;
  int          m_run;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt = 8'h00; m_valid = 1'b0; m_data = 8'h00; m_run = 0; m_cnt = 16'h0000;
  endtask

  // One cycle: drive at negedge, check ready, advance model at posedge, check outputs at next negedge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic y,
                      input bit verbose);
    logic [7:0] x;
    logic       acc;
    v_i = v; data_i = d; last_i = l; yumi_i = y;
    #1;
    chk("ready_o", {31'b0, ready_o}, {31'b0, (!m_valid || y)});
    @(posedge clk);
    acc = v && (!m_valid || y);
    if (m_valid && y) m_valid = 1'b0;
    if (acc) begin
      x = m_pkt ^ d[15:8] ^ d[7:0];
      m_run = m_run + 1;
      if (l) begin
        m_data  = x;
        m_valid = 1'b1;
        m_pkt   = 8'h00;
        m_cnt   = (m_run > 65535) ? 16'hFFFF : 16'(m_run);
        m_run   = 0;
        n_pkts++;
        if (verbose) $display("pkt %0d: checksum expected %02h", n_pkts, x);
      end else begin
        m_pkt = x;
      end
    end
    @(negedge clk);
    v_i = 1'b0; last_i = 1'b0; yumi_i = 1'b0;
    chk("v_o", {31'b0, v_o}, {31'b0, m_valid});
    chk("data_o", {24'b0, data_o}, {24'b0, m_data});
`ifdef BSG_XOR_CHECKSUM_COUNT_EN
    chk("count_o", {16'b0, count_o}, {16'b0, m_cnt});
`endif
  endtask

  logic [31:0] b_seq [3];

  initial begin
    reset_i = 1'b1; v_i = 1'b0; last_i = 1'b0; yumi_i = 1'b0; data_i = 16'h0;
    b_v = 1'b0; b_last = 1'b0; b_yumi = 1'b0; b_data = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_v_o", {31'b0, v_o}, 32'h0);
    chk("rst_ready_o", {31'b0, ready_o}, 32'h1);
    chk("rst_data_o", {24'b0, data_o}, 32'h0);
    reset_i = 1'b0;

    // Two-beat packet with two lanes per beat.
    step(1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0102, 1'b1, 1'b0, 1'b1);
    chk("t1_checksum", {24'b0, data_o}, 32'h0000_00FC);

    // Back-to-back single-beat packets with yumi held high.
    step(1'b1, 16'hAA55, 1'b1, 1'b1, 1'b1);
    chk("t2_checksum", {24'b0, data_o}, 32'h0000_00FF);
    for (int i = 0; i < 4; i++)
      step(1'b1, 16'($urandom), 1'b1, 1'b1, 1'b1);

    // Checksum pending while consumer stalls; offered beat must wait, not vanish.
    for (int i = 0; i < 5; i++) step(1'b1, 16'h3344, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h3344, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
    chk("t3_checksum", {24'b0, data_o}, 32'h0000_0076);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a packet.
    step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hC3C3, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h7777, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    #1 reset_i = 1'b1;
    #1;
    chk("t4_async_v_o", {31'b0, v_o}, 32'h0);
    chk("t4_async_ready", {31'b0, ready_o}, 32'h1);
    chk("t4_async_data", {24'b0, data_o}, 32'h0);
    #1 reset_i = 1'b0;
    model_reset();
    @(negedge clk);
    step(1'b1, 16'h1200, 1'b1, 1'b0, 1'b1);
    chk("t4_no_residue", {24'b0, data_o}, 32'h0000_0012);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Random traffic; yumi only ever offered while a checksum is expected to be pending.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) == 0),
           m_valid ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1);
    if (m_valid) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Single-lane 32-bit instance: identical words cancel.
    b_seq[0] = 32'hDEADBEEF; b_seq[1] = 32'hDEADBEEF; b_seq[2] = 32'h00000001;
    for (int i = 0; i < 3; i++) begin
      b_v = 1'b1; b_data = b_seq[i]; b_last = (i == 2);
      @(posedge clk);
      @(negedge clk);
    end
    b_v = 1'b0; b_last = 1'b0;
    chk("t5_v_o", {31'b0, b_v_o}, 32'h1);
    chk("t5_checksum", b_data_o, 32'h0000_0001);
    chk("t5_ready_stall", {31'b0, b_ready}, 32'h0);
    $display("pkt b: checksum expected 00000001");
    b_yumi = 1'b1;
    #1 chk("t5_ready_yumi", {31'b0, b_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    b_yumi = 1'b0;
    chk("t5_consumed", {31'b0, b_v_o}, 32'h0);

`ifdef BSG_XOR_CHECKSUM_COUNT_EN
    // Counter saturation on a very long packet, then a short one.
    for (int i = 0; i < 69999; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);
    chk("t6_saturate", {16'b0, count_o}, 32'h0000_FFFF);
    step(1'b1, 16'h0101, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h0202, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0404, 1'b1, 1'b0, 1'b1);
    chk("t6_count3", {16'b0, count_o}, 32'h0000_0003);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
